load_store_unit: RTL and testbench

Sits between the core's execute/memory stage and the byte-enabled data memory. It accepts one load/store request at a time, generates the word address, byte-lane mask and lane-replicated store data for the memory, and sign- or zero-extends load data. Misaligned, out-of-range and illegal-funct3 requests get an error response and never touch memory. The core side uses a valid/ready request channel and a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, error codes,
// FSM encoding and small request-classification helpers.
package lsu_pkg;

    // RV32I load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_DATA  = 2'b10,
        S_RESP  = 2'b11
    } lsu_state_e;

    // Stores only know B/H/W; loads additionally know BU/HU.
    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        logic legal;
        legal = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~write;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Halves need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = |offset;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/half out of a memory
// word and sign- or zero-extends it to 32 bits. Words pass through.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by width-dependent extension
    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time from the core, drives a byte-enabled
// data memory, returns extended load data or an error code.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int SIZE = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_read_ready,
    output logic [29:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic        mem_write_ready,
    output logic [29:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_byte
);

    localparam int ADDR = $clog2(SIZE);

    lsu_state_e  state_reg, state_next;
    logic        write_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] resp_rdata_reg;
    logic [1:0]  resp_err_reg;
    logic        mem_read_ready_reg;
    logic        mem_write_ready_reg;

    logic [1:0]  req_err;
    logic        req_in_range;
    logic [31:0] load_result;
    logic [31:0] store_data;
    logic [3:0]  store_mask;

    // Range check: any bit above the memory's address width is out of range,
    // and the low bits are compared too so non-power-of-two sizes work.
    assign req_in_range = (req_addr[31:ADDR] == '0) &&
                          ({{(32-ADDR){1'b0}}, req_addr[ADDR-1:0]} < 32'(SIZE));

    // Classify the incoming request: funct3, then alignment, then range
    always_comb begin
        req_err = ERR_OK;
        if (!funct3_legal(req_write, req_funct3)) begin
            req_err = ERR_FUNCT3;
        end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
            req_err = ERR_MISALIGN;
        end else if (!req_in_range) begin
            req_err = ERR_RANGE;
        end
    end

    // Store lane replication and byte enables, one generate slice per lane
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign store_data[8*gi +: 8] =
            (funct3_reg == F3_W) ? wdata_reg[8*gi +: 8] :
            (funct3_reg == F3_H) ? wdata_reg[8*(gi%2) +: 8] :
                                   wdata_reg[7:0];
        assign store_mask[gi] =
            (funct3_reg == F3_W) ? 1'b1 :
            (funct3_reg == F3_H) ? (addr_reg[1] == 1'(gi/2)) :
                                   (addr_reg[1:0] == 2'(gi));
    end

    lsu_load_align u_load_align (
        .rdata  (mem_read_data),
        .offset (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .result (load_result)
    );

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req_valid) state_next = (req_err != ERR_OK) ? S_RESP : S_ISSUE;
            S_ISSUE: state_next = write_reg ? S_RESP : S_DATA;
            S_DATA:  state_next = S_RESP;
            S_RESP:  if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request capture, one-cycle memory strobes and response data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            write_reg           <= 1'b0;
            funct3_reg          <= 3'b000;
            addr_reg            <= 32'h0;
            wdata_reg           <= 32'h0;
            resp_rdata_reg      <= 32'h0;
            resp_err_reg        <= ERR_OK;
            mem_read_ready_reg  <= 1'b0;
            mem_write_ready_reg <= 1'b0;
        end else begin
            // Strobes are only ever set on the IDLE->ISSUE edge, so they
            // last exactly the ISSUE cycle.
            mem_read_ready_reg  <= 1'b0;
            mem_write_ready_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        write_reg      <= req_write;
                        funct3_reg     <= req_funct3;
                        addr_reg       <= req_addr;
                        wdata_reg      <= req_wdata;
                        resp_rdata_reg <= 32'h0;
                        resp_err_reg   <= req_err;
                        if (req_err == ERR_OK) begin
                            mem_read_ready_reg  <= ~req_write;
                            mem_write_ready_reg <= req_write;
                        end
                    end
                end
                S_DATA: resp_rdata_reg <= load_result;
                S_RESP: begin
                    if (resp_ready) begin
                        resp_rdata_reg <= 32'h0;
                        resp_err_reg   <= ERR_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready         = (state_reg == S_IDLE);
    assign resp_valid        = (state_reg == S_RESP);
    assign resp_rdata        = resp_rdata_reg;
    assign resp_err          = resp_err_reg;
    assign mem_read_ready    = mem_read_ready_reg;
    assign mem_write_ready   = mem_write_ready_reg;
    // Address/data/mask buses are quiet unless their strobe is up
    assign mem_read_address  = mem_read_ready_reg  ? addr_reg[31:2] : 30'h0;
    assign mem_write_address = mem_write_ready_reg ? addr_reg[31:2] : 30'h0;
    assign mem_write_data    = mem_write_ready_reg ? store_data     : 32'h0;
    assign mem_write_byte    = mem_write_ready_reg ? store_mask     : 4'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-enabled memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_read_ready, mem_write_ready;
    logic [29:0] mem_read_address, mem_write_address;
    logic [31:0] mem_read_data, mem_write_data;
    logic [3:0]  mem_write_byte;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SIZE(4096)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_err          (resp_err),
        .mem_read_ready    (mem_read_ready),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data),
        .mem_write_ready   (mem_write_ready),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_byte    (mem_write_byte)
    );

    // 4 KiB byte-enabled memory, read data valid the cycle after the strobe
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_read_data = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_write_ready) begin
            for (int b = 0; b < 4; b++)
                if (mem_write_byte[b]) mem[mem_write_address[9:0]][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
        if (mem_read_ready) mem_read_data <= mem[mem_read_address[9:0]];
    end

    // Issue one request with resp_ready high; report latency, strobes, response
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output logic [1:0] err, output int lat, output int wr_cnt,
                          output int rd_cnt, output logic [3:0] wbyte, output logic [31:0] wdat);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = 1'b1;
        wr_cnt = 0; rd_cnt = 0; wbyte = 4'h0; wdat = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (1) begin
            if (mem_write_ready) begin wr_cnt++; wbyte = mem_write_byte; wdat = mem_write_data; end
            if (mem_read_ready) rd_cnt++;
            if (resp_valid || lat >= 10) break;
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err = resp_err;
        @(posedge clk); #1;
        $display("%s f3=%b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d wr=%0d rd=%0d",
                 wr ? "ST" : "LD", f3, a, wd, rdata, err, lat, wr_cnt, rd_cnt);
    endtask

    task automatic test_reset();
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        vectors++;
        if ({resp_valid, mem_read_ready, mem_write_ready} !== 3'b000) begin
            miscompares++; $display("FAIL reset_valids got=%b exp=000", {resp_valid, mem_read_ready, mem_write_ready});
        end
        vectors++;
        if ({resp_rdata, resp_err, mem_write_byte} !== 38'h0) begin
            miscompares++; $display("FAIL reset_data rdata=%h err=%b byte=%b exp=0", resp_rdata, resp_err, mem_write_byte);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, wdat; logic [1:0] err; logic [3:0] wb; int lat, wc, rc;
        do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if ({wb, wdat} !== {4'b1111, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL sw_lanes got=%b/%h exp=1111/deadbeef", wb, wdat);
        end
        vectors++;
        if (lat !== 2 || wc !== 1 || rc !== 0 || err !== 2'b00 || rd !== 32'h0) begin
            miscompares++; $display("FAIL sw_resp lat=%0d wr=%0d rd=%0d err=%b rdata=%h exp 2/1/0/00/0", lat, wc, rc, err, rd);
        end
        do_req(1'b0, F3_W, 32'h10, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'hDEADBEEF || err !== 2'b00) begin
            miscompares++; $display("FAIL lw_data got=%h err=%b exp=deadbeef/00", rd, err);
        end
        vectors++;
        if (lat !== 3 || rc !== 1 || wc !== 0) begin
            miscompares++; $display("FAIL lw_timing lat=%0d rd=%0d wr=%0d exp 3/1/0", lat, rc, wc);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, wdat; logic [1:0] err; logic [3:0] wb; int lat, wc, rc;
        do_req(1'b1, F3_B, 32'h13, 32'h000000A5, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if ({wb, wdat} !== {4'b1000, 32'hA5A5A5A5} || lat !== 2) begin
            miscompares++; $display("FAIL sb_lanes got=%b/%h lat=%0d exp=1000/a5a5a5a5 lat=2", wb, wdat, lat);
        end
        do_req(1'b0, F3_B, 32'h13, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'hFFFFFFA5) begin miscompares++; $display("FAIL lb_13 got=%h exp=ffffffa5", rd); end
        do_req(1'b0, F3_BU, 32'h13, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'h000000A5) begin miscompares++; $display("FAIL lbu_13 got=%h exp=000000a5", rd); end
        do_req(1'b0, F3_B, 32'h10, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'hFFFFFFEF) begin miscompares++; $display("FAIL lb_10 got=%h exp=ffffffef", rd); end
        do_req(1'b0, F3_BU, 32'h11, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'h000000BE) begin miscompares++; $display("FAIL lbu_11 got=%h exp=000000be", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd, wdat; logic [1:0] err; logic [3:0] wb; int lat, wc, rc;
        do_req(1'b1, F3_H, 32'h22, 32'h00008001, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if ({wb, wdat} !== {4'b1100, 32'h80018001}) begin
            miscompares++; $display("FAIL sh_lanes got=%b/%h exp=1100/80018001", wb, wdat);
        end
        do_req(1'b0, F3_H, 32'h22, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh_22 got=%h exp=ffff8001", rd); end
        do_req(1'b0, F3_HU, 32'h22, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'h00008001) begin miscompares++; $display("FAIL lhu_22 got=%h exp=00008001", rd); end
        do_req(1'b0, F3_W, 32'h20, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'h80010000) begin miscompares++; $display("FAIL lw_20 got=%h exp=80010000", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, wdat; logic [1:0] err; logic [3:0] wb; int lat, wc, rc;
        do_req(1'b0, F3_W, 32'h0E, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (err !== 2'b01 || lat !== 1 || wc + rc !== 0 || rd !== 32'h0) begin
            miscompares++; $display("FAIL lw_0e err=%b lat=%0d strobes=%0d rdata=%h exp 01/1/0/0", err, lat, wc + rc, rd);
        end
        do_req(1'b0, F3_H, 32'h0F, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (err !== 2'b01 || rc !== 0) begin miscompares++; $display("FAIL lh_0f err=%b rd=%0d exp 01/0", err, rc); end
        do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (err !== 2'b11 || rc !== 0 || lat !== 1) begin
            miscompares++; $display("FAIL ld_f3_011 err=%b rd=%0d lat=%0d exp 11/0/1", err, rc, lat);
        end
        do_req(1'b1, F3_W, 32'h1000, 32'h55555555, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (err !== 2'b10 || wc !== 0 || lat !== 1) begin
            miscompares++; $display("FAIL sw_1000 err=%b wr=%0d lat=%0d exp 10/0/1", err, wc, lat);
        end
        do_req(1'b1, F3_BU, 32'h1001, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (err !== 2'b11 || wc !== 0) begin miscompares++; $display("FAIL sbu_prio err=%b wr=%0d exp 11/0", err, wc); end
        do_req(1'b0, F3_W, 32'h1001, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (err !== 2'b01) begin miscompares++; $display("FAIL lw_prio err=%b exp 01", err); end
        do_req(1'b0, F3_W, 32'hFFC, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (err !== 2'b00 || lat !== 3 || rc !== 1) begin
            miscompares++; $display("FAIL lw_ffc err=%b lat=%0d rd=%0d exp 00/3/1", err, lat, rc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, wdat; logic [1:0] err; logic [3:0] wb; int lat, wc, rc, wait_cyc;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        // A store held on the request channel must be ignored while busy
        req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678;
        wait_cyc = 1;
        while (!resp_valid && wait_cyc < 10) begin @(posedge clk); #1; wait_cyc++; end
        vectors++;
        if (wait_cyc !== 3) begin miscompares++; $display("FAIL bp_latency got=%0d exp=3", wait_cyc); end
        wc = 0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5ADBEEF || resp_err !== 2'b00 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h err=%b req_ready=%b exp 1/a5adbeef/00/0",
                         c, resp_valid, resp_rdata, resp_err, req_ready);
            end
            if (mem_write_ready) wc++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || wc !== 0) begin
            miscompares++; $display("FAIL bp_release valid=%b req_ready=%b stray_wr=%0d exp 0/1/0", resp_valid, req_ready, wc);
        end
        $display("LD f3=010 addr=00000010 backpressured -> rdata=a5adbeef held 5 cycles");
        do_req(1'b0, F3_W, 32'h40, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL bp_ignored_store got=%h exp=00000000", rd); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd, wdat; logic [1:0] err; logic [3:0] wb; int lat, wc, rc;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++;
        if (mem_write_ready !== 1'b1) begin miscompares++; $display("FAIL rst_issue_strobe got=%b exp=1", mem_write_ready); end
        #1 resetn = 1'b0;
        #1;
        vectors++;
        if (mem_write_ready !== 1'b0 || mem_write_byte !== 4'h0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_async wr=%b byte=%b req_ready=%b resp_valid=%b exp 0/0000/1/0",
                                    mem_write_ready, mem_write_byte, req_ready, resp_valid);
        end
        $display("ST f3=010 addr=00000040 wdata=cafef00d -> aborted by reset in ISSUE");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, F3_W, 32'h20, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'h80010000 || err !== 2'b00 || lat !== 3) begin
            miscompares++; $display("FAIL rst_after_lw got=%h err=%b lat=%0d exp 80010000/00/3", rd, err, lat);
        end
        do_req(1'b0, F3_W, 32'h40, 32'h0, rd, err, lat, wc, rc, wb, wdat);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_no_commit got=%h exp=00000000", rd); end
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 test_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
